// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/long-press/auto-repeat pulses
//   clk           clock, rising edge
//   srst_n        synchronous active-low reset
//   d             debounced button level (1 = pressed)
//   long_width    long-press threshold in cycles (0 selects DEF_LONG)
//   repeat_width  auto-repeat period in cycles (0 selects DEF_REPEAT)
//   cnt_clr       synchronous clear of press_count (wins over a coincident press)
//   press         one-cycle pulse on press
//   release_evt   one-cycle pulse on release
//   long_press    one-cycle pulse after the button is held for the long-press threshold
//   repeat_evt    one-cycle pulse every repeat period after long_press while held
//   held          high while the button is considered pressed
//   press_count   saturating count of press pulses
module button_event #(
    parameter logic [31:0] DEF_LONG   = 32'd50_000_000,
    parameter logic [31:0] DEF_REPEAT = 32'd10_000_000
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        d,
    input  logic [31:0] long_width,
    input  logic [31:0] repeat_width,
    input  logic        cnt_clr,
    output logic        press,
    output logic        release_evt,
    output logic        long_press,
    output logic        repeat_evt,
    output logic        held,
    output logic [15:0] press_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] REPEAT  = 2'd2;
    logic [1:0]  state, state_nxt;
    logic [31:0] cntr, cntr_nxt, eff_long, eff_repeat;
    logic        d_prev, press_nxt, release_nxt, long_nxt, repeat_nxt;
    assign eff_long   = (long_width == '0) ? DEF_LONG : long_width;
    assign eff_repeat = (repeat_width == '0) ? DEF_REPEAT : repeat_width;
    // Release and unused encodings fall through to the IDLE/cntr=0 defaults.
    // The >= compares let a threshold lowered mid-hold fire immediately.
    always_comb begin
        state_nxt   = IDLE;
        cntr_nxt    = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: if (d && !d_prev) begin
                press_nxt = 1'b1;
                cntr_nxt  = 32'd1;
                state_nxt = PRESSED;
            end
            PRESSED: if (!d) begin
                release_nxt = 1'b1;
            end else if (cntr >= eff_long) begin
                long_nxt  = 1'b1;
                cntr_nxt  = 32'd1;
                state_nxt = REPEAT;
            end else begin
                cntr_nxt  = cntr + 32'd1;
                state_nxt = PRESSED;
            end
            REPEAT: if (!d) begin
                release_nxt = 1'b1;
            end else begin
                repeat_nxt = cntr >= eff_repeat;
                cntr_nxt   = repeat_nxt ? 32'd1 : cntr + 32'd1;
                state_nxt  = REPEAT;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state       <= IDLE;
            cntr        <= '0;
            d_prev      <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            held        <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            cntr        <= cntr_nxt;
            d_prev      <= d;
            press       <= press_nxt;
            release_evt <= release_nxt;
            long_press  <= long_nxt;
            repeat_evt  <= repeat_nxt;
            held        <= state_nxt != IDLE;
            press_count <= cnt_clr ? '0 :
                           (press_nxt && press_count != 16'hFFFF) ? press_count + 16'd1 : press_count;
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed self-checking bench for button_event
module tb_button_event;
    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        d = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] long_width = '0;
    logic [31:0] repeat_width = '0;
    logic        press, release_evt, long_press, repeat_evt, held;
    logic [15:0] press_count;
    int          n_checks = 0;
    int          n_fail = 0;
    button_event #(.DEF_LONG(32'd8), .DEF_REPEAT(32'd2)) dut (
        .clk(clk),
        .srst_n(srst_n),
        .d(d),
        .long_width(long_width),
        .repeat_width(repeat_width),
        .cnt_clr(cnt_clr),
        .press(press),
        .release_evt(release_evt),
        .long_press(long_press),
        .repeat_evt(repeat_evt),
        .held(held),
        .press_count(press_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Holds d for n edges starting at E0 (k=0), drops it so edge E0+n samples 0.
    // l and r are the effective thresholds the DUT should be using.
    task automatic run_hold(input int lw, input int rw, input int l, input int r, input int n);
        long_width   = 32'(lw);
        repeat_width = 32'(rw);
        for (int k = 0; k <= n; k++) begin
            d = k < n;
            tick();
            check("press",   32'(press),       32'(k == 0));
            check("long",    32'(long_press),  32'(k == l && k < n));
            check("repeat",  32'(repeat_evt),  32'(k > l && k < n && (k - l) % r == 0));
            check("release", 32'(release_evt), 32'(k == n));
            check("held",    32'(held),        32'(k < n));
        end
        tick();
    endtask
    initial begin
        d = 1'b1;
        tick();
        tick();
        check("rst_press",   32'(press),       0);
        check("rst_release", 32'(release_evt), 0);
        check("rst_long",    32'(long_press),  0);
        check("rst_repeat",  32'(repeat_evt),  0);
        check("rst_held",    32'(held),        0);
        check("rst_count",   32'(press_count), 0);
        srst_n = 1'b1;
        tick();
        check("first_press", 32'(press),       1);
        check("first_held",  32'(held),        1);
        check("first_count", 32'(press_count), 1);
        d = 1'b0;
        tick();
        check("first_release", 32'(release_evt), 1);
        check("first_unheld",  32'(held),        0);
        tick();
        run_hold(4, 3, 4, 3, 12);
        run_hold(5, 3, 5, 3, 5);
        run_hold(0, 0, 8, 2, 11);
        run_hold(1, 1, 1, 1, 5);
        long_width   = 32'd100;
        repeat_width = 32'd3;
        d = 1'b1;
        tick();
        check("l100_press", 32'(press), 1);
        for (int i = 0; i < 49; i++) begin
            tick();
            check("l100_no_long", 32'(long_press), 0);
        end
        long_width = 32'd10;
        tick();
        check("lower_long", 32'(long_press), 1);
        check("lower_held", 32'(held),       1);
        d = 1'b0;
        tick();
        check("lower_release", 32'(release_evt), 1);
        tick();
        d = 1'b1;
        tick();
        tick();
        tick();
        srst_n = 1'b0;
        tick();
        check("midrst_held",    32'(held),        0);
        check("midrst_release", 32'(release_evt), 0);
        check("midrst_count",   32'(press_count), 0);
        srst_n = 1'b1;
        tick();
        check("repress",      32'(press), 1);
        check("repress_held", 32'(held),  1);
        d = 1'b0;
        tick();
        check("repress_release", 32'(release_evt), 1);
        tick();
        force dut.press_count = 16'hFFFC;
        tick();
        release dut.press_count;
        tick();
        check("preload", 32'(press_count), 32'h0000FFFC);
        for (int i = 1; i <= 5; i++) begin
            d = 1'b1;
            tick();
            check("sat_count", 32'(press_count), (i < 3) ? 32'h0000FFFC + 32'(i) : 32'h0000FFFF);
            d = 1'b0;
            tick();
        end
        cnt_clr = 1'b1;
        d = 1'b1;
        tick();
        check("clr_press", 32'(press),       1);
        check("clr_count", 32'(press_count), 0);
        cnt_clr = 1'b0;
        d = 1'b0;
        tick();
        d = 1'b1;
        tick();
        check("after_clr", 32'(press_count), 1);
        d = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_event.md
# button_event

Event generator that sits directly downstream of the debouncer and consumes its clean level output. It converts the debounced button level into single-cycle event pulses: press, release, long-press, and periodic auto-repeat while held. It also keeps a saturating press counter. Its outputs drive control logic that needs edge-style events rather than levels.

## Interface

Parameters:
- DEF_LONG, 32'd50_000_000: long-press threshold in cycles, used when `long_width` is 0
- DEF_REPEAT, 32'd10_000_000: auto-repeat period in cycles, used when `repeat_width` is 0

Ports:
- clk  input  1  clock; all logic on rising edge
- srst_n  input  1  reset, synchronous, active-low
- d  input  1  debounced button level (1 = pressed)
- long_width  input  32  long-press threshold L in cycles (0 → DEF_LONG)
- repeat_width  input  32  repeat period R in cycles (0 → DEF_REPEAT)
- cnt_clr  input  1  synchronous clear of `press_count`
- press  output  1  one-cycle pulse on press
- release  output  1  one-cycle pulse on release
- long_press  output  1  one-cycle pulse when held for L cycles
- repeat  output  1  one-cycle pulse every R cycles after long_press while held
- held  output  1  level; 1 while state ≠ IDLE
- press_count  output  16  number of press events, saturates at 16'hFFFF

## Operation

- All outputs are registered. Reset (srst_n=0 at an edge) sets all outputs to 0, state IDLE, cntr 0, d_prev 0.
- Effective L and R are resolved combinationally every cycle from the width inputs, with zero selecting the default.
- `d_prev` holds the previous `d` sample. A rise is d=1 with d_prev=0; a fall is d=0 with d_prev=1.
- States: IDLE, PRESSED, REPEAT.
  - IDLE: on rise, pulse press, cntr←1, go to PRESSED. Otherwise stay, cntr←0.
  - PRESSED: if d=0, pulse release, cntr←0, go to IDLE. Else if cntr ≥ L, pulse long_press, cntr←1, go to REPEAT. Else cntr←cntr+1.
  - REPEAT: if d=0, pulse release, cntr←0, go to IDLE. Else if cntr ≥ R, pulse repeat, cntr←1. Else cntr←cntr+1.
  - Any unused encoding goes to IDLE with cntr←0.
- Release has priority over long_press and repeat on the same edge. At most one event pulse is high in any cycle.
- cntr is 32 bits. The ≥ compare means a width lowered mid-hold below cntr fires on the next edge and never wraps.
- press_count increments by 1 on each press pulse and saturates at 16'hFFFF.
  - cnt_clr has priority: clear and press on the same edge leave the count at 0.
- If d=1 on the first edge after reset, it is treated as a rise and press fires.

## Timing

- Edge E0 is the first edge that samples d=1 after d=0. press is high for the cycle after E0, and held rises at the same time.
- long_press is high for the cycle after edge E0+L. repeat pulses follow edges E0+L+k·R, for k ≥ 1.
- Edge E1 is the first edge sampling d=0 while held. release is high for the cycle after E1, and held falls at the same time.
- With L=1, long_press follows E0+1. With R=1, repeat is high on every cycle after E0+L+1 while held.
- A reset edge mid-hold returns the block to IDLE with no release pulse. If d is still 1 on the next edge, press fires again.

## Test plan

- Reset with d=1, then release reset → press after the first edge, held=1, press_count=1; all outputs 0 during reset.
- L=4, R=3, hold d=1 for 12 cycles from E0, then drop:
  - press after E0, long_press after E0+4, repeat after E0+7 and E0+10;
  - release after E0+12, held falls with it.
- L=5, drop d exactly at edge E0+5 → release pulses; long_press never asserts.
- long_width=0, repeat_width=0 with DEF_LONG=8, DEF_REPEAT=2 overridden → long_press after E0+8, repeat after E0+10.
- L=100, at cntr=50 change long_width to 10 → long_press on the next edge, no counter wrap.
- Preload press_count to 16'hFFFE via 2 presses from 16'hFFFC, then 3 more presses → count stays 16'hFFFF; cnt_clr coincident with a press → 0.
